gshare_pht: RTL and testbench

- Reader/consumer side of the global branch history register. Takes the 3-bit history (`ghr_out`) and a branch PC, XOR-indexes a pattern history table of 2-bit saturating counters, and returns a registered taken/not-taken prediction.
- On branch resolution it trains the indexed counter. One cycle later it drives the history register's `update_en`/`in_bit` inputs with the resolved outcome, closing the loop.

---
 rtl/gshare_pht.sv | 93 +++++++++
 tb/tb_gshare_pht.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/gshare_pht.sv
// Gshare predictor: PC XOR global history indexes 2-bit saturating counters. Prediction and mispredict flag are
// registered, so both appear 1 cycle after their strobe. No backpressure: every pred_req and upd_en is accepted.
module gshare_pht #(
    parameter int         IDX_W    = 3,
    parameter int         PC_W     = 8,
    parameter int         PC_LSB   = 0,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pred_req,
    input  logic [PC_W-1:0]  pred_pc,
    input  logic [IDX_W-1:0] ghr_in,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_idx,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    output logic             upd_mispredict,
    output logic             ghr_shift_en,
    output logic             ghr_shift_bit
);
    localparam int DEPTH = 1 << IDX_W;

    logic [1:0]       pht_q [DEPTH];
    logic [1:0]       pht_d [DEPTH];
    logic [IDX_W-1:0] idx;
    logic [1:0]       upd_cnt;
    logic             unused_pc;

    logic             pred_valid_q, pred_valid_d;
    logic             pred_taken_q, pred_taken_d;
    logic [IDX_W-1:0] pred_idx_q, pred_idx_d;
    logic             upd_mispredict_q, upd_mispredict_d;
    logic             ghr_shift_en_q, ghr_shift_en_d;
    logic             ghr_shift_bit_q, ghr_shift_bit_d;

    assign idx       = pred_pc[PC_LSB +: IDX_W] ^ ghr_in;
    assign upd_cnt   = pht_q[upd_idx];
    assign unused_pc = ^pred_pc;

    // The prediction reads pht_q, so a same-cycle update to the same entry is not bypassed.
    always_comb begin
        pht_d            = pht_q;
        pred_valid_d     = pred_req;
        pred_taken_d     = pred_taken_q;
        pred_idx_d       = pred_idx_q;
        upd_mispredict_d = 1'b0;
        ghr_shift_en_d   = upd_en;
        ghr_shift_bit_d  = ghr_shift_bit_q;
        if (pred_req) begin
            pred_taken_d = pht_q[idx][1];
            pred_idx_d   = idx;
        end
        if (upd_en) begin
            upd_mispredict_d = (upd_cnt[1] != upd_taken);
            ghr_shift_bit_d  = upd_taken;
            if (upd_taken) begin
                if (upd_cnt != 2'b11) pht_d[upd_idx] = upd_cnt + 2'd1;
            end else begin
                if (upd_cnt != 2'b00) pht_d[upd_idx] = upd_cnt - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) pht_q[i] <= CNT_INIT;
            pred_valid_q     <= 1'b0;
            pred_taken_q     <= 1'b0;
            pred_idx_q       <= '0;
            upd_mispredict_q <= 1'b0;
            ghr_shift_en_q   <= 1'b0;
            ghr_shift_bit_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) pht_q[i] <= pht_d[i];
            pred_valid_q     <= pred_valid_d;
            pred_taken_q     <= pred_taken_d;
            pred_idx_q       <= pred_idx_d;
            upd_mispredict_q <= upd_mispredict_d;
            ghr_shift_en_q   <= ghr_shift_en_d;
            ghr_shift_bit_q  <= ghr_shift_bit_d;
        end
    end

    assign pred_valid     = pred_valid_q;
    assign pred_taken     = pred_taken_q;
    assign pred_idx       = pred_idx_q;
    assign upd_mispredict = upd_mispredict_q;
    assign ghr_shift_en   = ghr_shift_en_q;
    assign ghr_shift_bit  = ghr_shift_bit_q;
endmodule

// File: tb/tb_gshare_pht.sv
// Bench for gshare_pht: directed scenarios plus random traffic against an array-of-integers counter model,
// with a local 3-bit history register closing the shift loop.
module tb_gshare_pht;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pred_req = 1'b0;
    logic [7:0] pred_pc = '0;
    logic [2:0] ghr_in = '0;
    logic       upd_en = 1'b0;
    logic [2:0] upd_idx = '0;
    logic       upd_taken = 1'b0;
    logic       pred_valid, pred_taken, upd_mispredict, ghr_shift_en, ghr_shift_bit;
    logic [2:0] pred_idx;
    logic [2:0] hist;

    int errors = 0;
    int checks = 0;

    // Reference state: counters as plain integers 0..3, plus expected registered outputs.
    int         cnt_m [8];
    logic       m_valid, m_taken, m_mis, m_sen, m_sbit;
    logic [2:0] m_idx;

    always #5 clk = ~clk;

    gshare_pht dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pred_req      (pred_req),
        .pred_pc       (pred_pc),
        .ghr_in        (ghr_in),
        .pred_valid    (pred_valid),
        .pred_taken    (pred_taken),
        .pred_idx      (pred_idx),
        .upd_en        (upd_en),
        .upd_idx       (upd_idx),
        .upd_taken     (upd_taken),
        .upd_mispredict(upd_mispredict),
        .ghr_shift_en  (ghr_shift_en),
        .ghr_shift_bit (ghr_shift_bit)
    );

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)          hist <= 3'b000;
        else if (ghr_shift_en) hist <= {hist[1:0], ghr_shift_bit};
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) cnt_m[i] = 1;
        m_valid = 0; m_taken = 0; m_idx = 0; m_mis = 0; m_sen = 0; m_sbit = 0;
    endtask

    task automatic check_outs(input string tag);
        check_val({tag, ".valid"}, {31'd0, pred_valid}, {31'd0, m_valid});
        check_val({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, m_taken});
        check_val({tag, ".idx"}, {29'd0, pred_idx}, {29'd0, m_idx});
        check_val({tag, ".mis"}, {31'd0, upd_mispredict}, {31'd0, m_mis});
        check_val({tag, ".sen"}, {31'd0, ghr_shift_en}, {31'd0, m_sen});
        check_val({tag, ".sbit"}, {31'd0, ghr_shift_bit}, {31'd0, m_sbit});
    endtask

    // One clock: drive inputs, take the edge, advance the model with prediction-before-update, then compare.
    task automatic step(input logic pr, input logic [7:0] pc, input logic [2:0] g,
                        input logic ue, input logic [2:0] ui, input logic ut, input string tag);
        int c;
        pred_req = pr; pred_pc = pc; ghr_in = g;
        upd_en = ue; upd_idx = ui; upd_taken = ut;
        @(posedge clk);
        #1;
        m_valid = pr;
        if (pr) begin
            m_idx   = pc[2:0] ^ g;
            m_taken = (cnt_m[m_idx] >= 2);
        end
        m_sen = ue;
        m_mis = 0;
        if (ue) begin
            c      = cnt_m[ui];
            m_mis  = ((c >= 2) != ut);
            m_sbit = ut;
            cnt_m[ui] = ut ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
        end
        check_outs(tag);
    endtask

    initial begin
        model_reset();
        #12;
        check_outs("reset");
        reset_n = 1'b1;

        step(1, 8'h05, 3'b011, 0, 0, 0, "pred0");
        check_val("pred0_idx6", {29'd0, pred_idx}, 32'd6);
        check_val("pred0_nt", {31'd0, pred_taken}, 32'd0);

        step(0, 0, 0, 1, 3'd6, 1, "upd6a");
        check_val("upd6a_mis", {31'd0, upd_mispredict}, 32'd1);
        check_val("upd6a_sbit", {31'd0, ghr_shift_bit}, 32'd1);
        step(0, 0, 0, 1, 3'd6, 1, "upd6b");
        check_val("upd6b_mis", {31'd0, upd_mispredict}, 32'd0);
        step(1, 8'h06, 3'b000, 0, 0, 0, "pred6");
        check_val("pred6_t", {31'd0, pred_taken}, 32'd1);

        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 3'd6, 1, "sat_hi");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 3'd6, 0, "sat_dn");
        step(1, 8'h06, 3'b000, 1, 3'd6, 1, "sat_lo_pred");
        check_val("sat_lo_nt", {31'd0, pred_taken}, 32'd0);

        step(1, 8'h02, 3'b000, 1, 3'd2, 1, "same2a");
        check_val("same2a_old", {31'd0, pred_taken}, 32'd0);
        step(1, 8'h02, 3'b000, 0, 0, 0, "same2b");
        check_val("same2b_new", {31'd0, pred_taken}, 32'd1);

        // Asynchronous reset with both strobes active.
        step(1, 8'h02, 3'b000, 1, 3'd6, 1, "pre_rst");
        pred_req = 1; upd_en = 1; upd_idx = 3'd6; upd_taken = 1;
        #5 reset_n = 1'b0;
        #1;
        model_reset();
        check_outs("arst_now");
        @(posedge clk);
        #1;
        check_outs("arst_edge");
        pred_req = 0; upd_en = 0;
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1, 8'(i), 3'b000, 0, 0, 0, "post_rst");
            check_val("post_rst_sen", {31'd0, ghr_shift_en}, 32'd0);
        end

        step(0, 0, 0, 1, 3'd7, 1, "loop1");
        step(0, 0, 0, 1, 3'd7, 0, "loop0");
        step(0, 0, 0, 1, 3'd7, 1, "loop1b");
        step(0, 0, 0, 0, 0, 0, "loop_idle");
        check_val("loop_hist", {29'd0, hist}, 32'd5);
        step(1, 8'h00, hist, 0, 0, 0, "loop_pred");
        check_val("loop_idx", {29'd0, pred_idx}, 32'd5);

        for (int n = 0; n < 400; n++) begin
            logic [7:0] pc;
            logic [2:0] ui;
            pc = 8'($urandom);
            ui = ($urandom_range(0, 3) == 0) ? (pc[2:0] ^ hist) : 3'($urandom);
            step(1'($urandom), pc, hist, 1'($urandom), ui, 1'($urandom), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
